// File: rtl/bitmask_match_scanner.sv
// bitmask_match_scanner: latches an activation mask and a weight-nonzero mask,
// then emits every position set in both, lowest first, paired with its
// compressed weight read from an external synchronous SRAM. The SRAM address
// of a position is weight_base plus the number of weight-nonzero bits below it.
// Optional build macro SCANNER_STATS_EN adds saturating match/stall counters.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a presented match (position, weight)
// stays unchanged until it is taken.
module bitmask_match_scanner #(
  parameter int BITMASK_WIDTH = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [BITMASK_WIDTH-1:0]         bitmask_a,
  input  logic [BITMASK_WIDTH-1:0]         bitmask_b,
  input  logic [ADDR_WIDTH-1:0]            weight_base,
  output logic [BITMASK_WIDTH-1:0]         and_result,
  output logic [BITMASK_WIDTH-1:0]         bitmask_a_out,
  output logic                             weight_rd_en,
  output logic [ADDR_WIDTH-1:0]            weight_addr,
  input  logic [WEIGHT_WIDTH-1:0]          weight_rdata,
  output logic                             match_valid,
  input  logic                             match_ready,
  output logic [$clog2(BITMASK_WIDTH)-1:0] matched_position,
  output logic [WEIGHT_WIDTH-1:0]          matched_weight,
  output logic                             scan_done
`ifdef SCANNER_STATS_EN
  ,
  output logic [15:0]                      stat_matches,
  output logic [15:0]                      stat_stall_cycles
`endif
);

  localparam int POS_WIDTH = $clog2(BITMASK_WIDTH);
  localparam logic [BITMASK_WIDTH-1:0] ONE_HOT0 = BITMASK_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [BITMASK_WIDTH-1:0] a_q, b_q, and_q, remaining;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic                     inflight_v;
  logic [POS_WIDTH-1:0]     inflight_pos;
  logic                     skid_v;
  logic [POS_WIDTH-1:0]     skid_pos;
  logic [WEIGHT_WIDTH-1:0]  skid_data;
  logic                     out_v;
  logic [POS_WIDTH-1:0]     out_pos;
  logic [WEIGHT_WIDTH-1:0]  out_data;
  logic                     done_q;

  logic                     load_fire, accept, issue, drain_exit, load_empty;
  logic [POS_WIDTH-1:0]     issue_pos;
  logic [BITMASK_WIDTH-1:0] remaining_after;

  function automatic logic [POS_WIDTH-1:0] lowest_bit(input logic [BITMASK_WIDTH-1:0] m);
    logic [POS_WIDTH-1:0] p;
    p = '0;
    for (int i = BITMASK_WIDTH - 1; i >= 0; i--) begin
      if (m[i]) p = i[POS_WIDTH-1:0];
    end
    return p;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] count_below(input logic [BITMASK_WIDTH-1:0] m,
                                                        input logic [POS_WIDTH-1:0] pos);
    logic [ADDR_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BITMASK_WIDTH; i++) begin
      if (i < int'(pos) && m[i]) cnt = cnt + ADDR_WIDTH'(1);
    end
    return cnt;
  endfunction

  // Issue control: one read per cycle, but only when its data is sure to find
  // a free slot (output register or skid) the cycle it returns.
  always_comb begin
    load_ready      = (state_q == IDLE);
    load_fire       = load_valid && load_ready;
    load_empty      = ((bitmask_a & bitmask_b) == '0);
    accept          = out_v && match_ready;
    issue_pos       = lowest_bit(remaining);
    remaining_after = remaining & ~(ONE_HOT0 << issue_pos);
    issue           = (state_q == SCAN) && (remaining != '0) && !skid_v &&
                      !(out_v && inflight_v && !match_ready);
    drain_exit      = (state_q == DRAIN) && !inflight_v && !skid_v && accept;
    weight_rd_en    = issue;
    weight_addr     = '0;
    if (issue) weight_addr = base_q + count_below(b_q, issue_pos);
  end

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_fire && !load_empty) state_d = SCAN;
      SCAN:    if (issue && (remaining_after == '0)) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Mask capture, issue bookkeeping, return path into output/skid, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      and_q        <= '0;
      remaining    <= '0;
      base_q       <= '0;
      inflight_v   <= 1'b0;
      inflight_pos <= '0;
      skid_v       <= 1'b0;
      skid_pos     <= '0;
      skid_data    <= '0;
      out_v        <= 1'b0;
      out_pos      <= '0;
      out_data     <= '0;
      done_q       <= 1'b0;
    end else begin
      if (load_fire) begin
        a_q       <= bitmask_a;
        b_q       <= bitmask_b;
        and_q     <= bitmask_a & bitmask_b;
        remaining <= bitmask_a & bitmask_b;
        base_q    <= weight_base;
      end else if (issue) begin
        remaining <= remaining_after;
      end

      inflight_v <= issue;
      if (issue) inflight_pos <= issue_pos;

      // Older data in the skid always reaches the output before newer returns.
      if (!out_v || accept) begin
        if (skid_v) begin
          out_v    <= 1'b1;
          out_pos  <= skid_pos;
          out_data <= skid_data;
          skid_v   <= inflight_v;
          if (inflight_v) begin
            skid_pos  <= inflight_pos;
            skid_data <= weight_rdata;
          end
        end else if (inflight_v) begin
          out_v    <= 1'b1;
          out_pos  <= inflight_pos;
          out_data <= weight_rdata;
        end else begin
          out_v <= 1'b0;
        end
      end else if (inflight_v) begin
        skid_v    <= 1'b1;
        skid_pos  <= inflight_pos;
        skid_data <= weight_rdata;
      end

      done_q <= (load_fire && load_empty) || drain_exit;
    end
  end

`ifdef SCANNER_STATS_EN
  // Saturating activity counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_matches      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (accept && (stat_matches != 16'hFFFF))
        stat_matches <= stat_matches + 16'd1;
      if (out_v && !match_ready && (stat_stall_cycles != 16'hFFFF))
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif

  assign and_result       = and_q;
  assign bitmask_a_out    = a_q;
  assign match_valid      = out_v;
  assign matched_position = out_pos;
  assign matched_weight   = out_data;
  assign scan_done        = done_q;

endmodule

// File: tb/tb_bitmask_match_scanner.sv
// Testbench for bitmask_match_scanner: SRAM model, negedge monitor, reference
// model computing expected (position, weight, address) lists from the masks.
module tb_bitmask_match_scanner;

  localparam int W  = 16;
  localparam int WW = 8;
  localparam int AW = 10;
  localparam int PW = 4;

  logic          clk, rst_n;
  logic          load_valid, load_ready;
  logic [W-1:0]  bitmask_a, bitmask_b, and_result, bitmask_a_out;
  logic [AW-1:0] weight_base, weight_addr;
  logic          weight_rd_en;
  logic [WW-1:0] weight_rdata, matched_weight;
  logic          match_valid, match_ready, scan_done;
  logic [PW-1:0] matched_position;
`ifdef SCANNER_STATS_EN
  logic [15:0]   stat_matches, stat_stall_cycles;
`endif

  bitmask_match_scanner dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .bitmask_a(bitmask_a), .bitmask_b(bitmask_b), .weight_base(weight_base),
    .and_result(and_result), .bitmask_a_out(bitmask_a_out),
    .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_rdata(weight_rdata),
    .match_valid(match_valid), .match_ready(match_ready),
    .matched_position(matched_position), .matched_weight(matched_weight),
    .scan_done(scan_done)
`ifdef SCANNER_STATS_EN
    , .stat_matches(stat_matches), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SRAM model ----------------
  logic [WW-1:0] mem [1024];
  always @(posedge clk) if (weight_rd_en) weight_rdata <= mem[weight_addr];

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] exp_pos_q[$];
  logic [WW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [PW-1:0] obs_pos_q[$];
  logic [WW-1:0] obs_w_q[$];
  logic [AW-1:0] obs_addr_q[$];

  int cyc = 0;
  int load_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  int done_count, rd_count, stall_count, hold_err;
  bit prev_stall;
  logic [PW-1:0] prev_pos;
  logic [WW-1:0] prev_w;

  // ---------------- monitor (samples at negedge) ----------------
  always @(negedge clk) begin
    cyc++;
    if (load_valid && load_ready) load_cyc = cyc;
    if (weight_rd_en) begin
      obs_addr_q.push_back(weight_addr);
      rd_count++;
    end
    if (match_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && (!match_valid || matched_position !== prev_pos || matched_weight !== prev_w))
      hold_err++;
    prev_stall = match_valid && !match_ready;
    prev_pos   = matched_position;
    prev_w     = matched_weight;
    if (match_valid && !match_ready) stall_count++;
    if (match_valid && match_ready) begin
      obs_pos_q.push_back(matched_position);
      obs_w_q.push_back(matched_weight);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (scan_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic clear_obs();
    obs_pos_q.delete(); obs_w_q.delete(); obs_addr_q.delete();
    load_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    done_cyc = -1; done_count = 0; rd_count = 0; stall_count = 0; hold_err = 0;
    prev_stall = 1'b0;
  endtask

  // Reference model: walk the masks in ascending order keeping a running
  // count of weight-nonzero bits seen so far (the compressed weight index).
  task automatic build_model(input logic [W-1:0] a, input logic [W-1:0] b, input int base);
    int rank;
    int addr;
    exp_pos_q.delete(); exp_q.delete(); exp_addr_q.delete();
    rank = 0;
    for (int p = 0; p < W; p++) begin
      if (a[p] && b[p]) begin
        addr = (base + rank) % 1024;
        exp_pos_q.push_back(PW'(p));
        exp_q.push_back(mem[addr]);
        exp_addr_q.push_back(AW'(addr));
      end
      if (b[p]) rank++;
    end
  endtask

  // Index of first difference between observed and expected matches; -1 if equal.
  function automatic int match_diff();
    if (obs_pos_q.size() != exp_pos_q.size()) return -2;
    foreach (exp_pos_q[i])
      if (obs_pos_q[i] !== exp_pos_q[i] || obs_w_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int addr_diff();
    if (obs_addr_q.size() != exp_addr_q.size()) return -2;
    foreach (exp_addr_q[i])
      if (obs_addr_q[i] !== exp_addr_q[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [AW-1:0] base);
    load_valid = 1'b1; bitmask_a = a; bitmask_b = b; weight_base = base;
    @(posedge clk); #1;
    load_valid = 1'b0; bitmask_a = $urandom; bitmask_b = $urandom; weight_base = AW'($urandom);
  endtask

  task automatic run_until_done(input bit rand_ready, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (rand_ready) match_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (done_count > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    match_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({load_ready, match_valid, weight_rd_en, scan_done} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b, want 1000", {load_ready, match_valid, weight_rd_en, scan_done});
    else n_pass++;
    n_checks++;
    if ({and_result, bitmask_a_out, matched_position, matched_weight, weight_addr} !== '0)
      $display("FAIL reset_data: and=%h a=%h pos=%0d w=%h addr=%h, want all 0",
               and_result, bitmask_a_out, matched_position, matched_weight, weight_addr);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_pairing();
    bit to;
    mem[10'h040] = 8'h2C; mem[10'h042] = 8'h5A;
    clear_obs();
    build_model(16'h002C, 16'h0034, 10'h040);
    do_load(16'h002C, 16'h0034, 10'h040);
    run_until_done(1'b0, to);
    n_checks++;
    if (to) $display("FAIL basic_timeout: scan_done not seen, want pulse"); else n_pass++;
    n_checks++;
    if (and_result !== 16'h0024) $display("FAIL basic_and: got %h, want 0024", and_result); else n_pass++;
    n_checks++;
    if (bitmask_a_out !== 16'h002C) $display("FAIL basic_a_out: got %h, want 002C", bitmask_a_out); else n_pass++;
    n_checks++;
    if (obs_pos_q.size() != 2 || obs_pos_q[0] !== 4'd2 || obs_w_q[0] !== 8'h2C ||
        obs_pos_q[1] !== 4'd5 || obs_w_q[1] !== 8'h5A)
      $display("FAIL basic_matches: got %0d matches first (%0d,%h), want (2,2C),(5,5A)",
               obs_pos_q.size(), obs_pos_q.size() > 0 ? obs_pos_q[0] : 4'd0,
               obs_w_q.size() > 0 ? obs_w_q[0] : 8'd0);
    else n_pass++;
    n_checks++;
    if (addr_diff() != -1 || obs_addr_q.size() != 2)
      $display("FAIL basic_addr: diff at %0d of %0d reads, want 040,042", addr_diff(), obs_addr_q.size());
    else n_pass++;
    n_checks++;
    if (first_valid_cyc != load_cyc + 3)
      $display("FAIL basic_latency: got %0d cycles, want 3", first_valid_cyc - load_cyc);
    else n_pass++;
    n_checks++;
    if (last_acc_cyc != first_acc_cyc + 1)
      $display("FAIL basic_consecutive: accepts %0d apart, want 1", last_acc_cyc - first_acc_cyc);
    else n_pass++;
    n_checks++;
    if (done_cyc != last_acc_cyc + 1 || done_count != 1)
      $display("FAIL basic_done: done %0d after last accept (count %0d), want 1 (1)",
               done_cyc - last_acc_cyc, done_count);
    else n_pass++;
  endtask

  task automatic test_empty_and();
    bit to;
    clear_obs();
    do_load(16'h00F0, 16'h000F, 10'h123);
    run_until_done(1'b0, to);
    @(posedge clk); #1;
    n_checks++;
    if (to || done_cyc != load_cyc + 1 || done_count != 1)
      $display("FAIL empty_done: done at +%0d count %0d, want +1 count 1", done_cyc - load_cyc, done_count);
    else n_pass++;
    n_checks++;
    if (rd_count != 0 || first_valid_cyc != -1)
      $display("FAIL empty_activity: reads %0d valid_cyc %0d, want 0 and none", rd_count, first_valid_cyc);
    else n_pass++;
    n_checks++;
    if (load_ready !== 1'b1) $display("FAIL empty_ready: got %b, want 1", load_ready); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    bit seen;
    logic [AW-1:0] base;
    apply_reset();
    base = AW'($urandom);
    clear_obs();
    build_model(16'h000F, 16'h000F, base);
    do_load(16'h000F, 16'h000F, base);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (match_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) $display("FAIL bp_valid_timeout: match_valid never rose, want 1"); else n_pass++;
    match_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (matched_position !== 4'd0 || matched_weight !== mem[base] || !match_valid)
      $display("FAIL bp_hold_value: got v=%b (%0d,%h), want 1 (0,%h)",
               match_valid, matched_position, matched_weight, mem[base]);
    else n_pass++;
    n_checks++;
    if (rd_count != 2) $display("FAIL bp_reads: got %0d reads during stall, want 2", rd_count); else n_pass++;
    match_ready = 1'b1;
    run_until_done(1'b0, to);
    n_checks++;
    if (to || match_diff() != -1)
      $display("FAIL bp_order: diff at %0d (got %0d matches), want 4 in order", match_diff(), obs_pos_q.size());
    else n_pass++;
    n_checks++;
    if (hold_err != 0 || stall_count != 4)
      $display("FAIL bp_stall: hold errors %0d stall cycles %0d, want 0 and 4", hold_err, stall_count);
    else n_pass++;
`ifdef SCANNER_STATS_EN
    n_checks++;
    if (stat_matches !== 16'd4 || stat_stall_cycles !== 16'd4)
      $display("FAIL bp_stats: got matches %0d stalls %0d, want 4 and 4", stat_matches, stat_stall_cycles);
    else n_pass++;
`endif
  endtask

  task automatic test_full_wrap();
    bit to;
    clear_obs();
    build_model(16'hFFFF, 16'hFFFF, 10'h3FE);
    do_load(16'hFFFF, 16'hFFFF, 10'h3FE);
    run_until_done(1'b0, to);
    n_checks++;
    if (to || obs_pos_q.size() != 16 || match_diff() != -1)
      $display("FAIL full_matches: got %0d matches diff %0d, want 16 in order", obs_pos_q.size(), match_diff());
    else n_pass++;
    n_checks++;
    if (addr_diff() != -1 || obs_addr_q[2] !== 10'h000 || obs_addr_q[15] !== 10'h00D)
      $display("FAIL full_wrap_addr: diff at %0d, want 3FE,3FF,000..00D", addr_diff());
    else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    logic [W-1:0] a, b;
    logic [AW-1:0] base;
    for (int n = 0; n < 20; n++) begin
      a = W'($urandom) & W'($urandom | $urandom);
      b = W'($urandom) | ((n % 4 == 0) ? W'($urandom) : '0);
      base = AW'($urandom);
      clear_obs();
      build_model(a, b, base);
      do_load(a, b, base);
      run_until_done(1'b1, to);
      n_checks++;
      if (to || match_diff() != -1 || addr_diff() != -1)
        $display("FAIL rand_seq%0d: a=%h b=%h match diff %0d addr diff %0d, want -1 -1",
                 n, a, b, match_diff(), addr_diff());
      else n_pass++;
      n_checks++;
      if (hold_err != 0 || done_count != 1)
        $display("FAIL rand_hold%0d: hold errors %0d done pulses %0d, want 0 and 1", n, hold_err, done_count);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_scan();
    bit to;
    logic [AW-1:0] base;
    clear_obs();
    do_load(16'h0FF0, 16'h0FF0, 10'h200);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({load_ready, match_valid, weight_rd_en, scan_done} !== 4'b1000 ||
        {and_result, bitmask_a_out, matched_position, matched_weight, weight_addr} !== '0)
      $display("FAIL midrst_outputs: ctrl %b and=%h pos=%0d w=%h addr=%h, want 1000 and zeros",
               {load_ready, match_valid, weight_rd_en, scan_done}, and_result,
               matched_position, matched_weight, weight_addr);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    base = AW'($urandom);
    clear_obs();
    build_model(16'h0001, 16'h0001, base);
    do_load(16'h0001, 16'h0001, base);
    run_until_done(1'b0, to);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (to || obs_pos_q.size() != 1 || match_diff() != -1)
      $display("FAIL midrst_fresh: got %0d matches diff %0d, want single (0,%h)",
               obs_pos_q.size(), match_diff(), mem[base]);
    else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0; load_valid = 1'b0; match_ready = 1'b1;
    bitmask_a = '0; bitmask_b = '0; weight_base = '0;
    for (int i = 0; i < 1024; i++) mem[i] = WW'($urandom);
    clear_obs();
    test_reset();
    test_basic_pairing();
    test_empty_and();
    test_backpressure();
    test_full_wrap();
    test_random();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bitmask_match_scanner.md
Name: bitmask_match_scanner

Overview:
- Upstream feeder of the laggy prefix stage.
- Latches one activation bitmask (bitmask_a) and one weight-nonzero bitmask (bitmask_b) and forms and_result = a & b.
- Emits every matched position lowest-first, at most one per cycle. Each match is paired with its compressed weight, read from an external synchronous weight SRAM.
- The SRAM address is weight_base + popcount(bitmask_b below the position), a fast prefix count.

Parameters:
- BITMASK_WIDTH, 16, width of both bitmasks.
- WEIGHT_WIDTH, 8, weight data width.
- ADDR_WIDTH, 10, weight SRAM address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  new mask pair offered.
- load_ready  out  1  scanner idle; load accepted when load_valid && load_ready.
- bitmask_a  in  BITMASK_WIDTH  activation mask, sampled on load.
- bitmask_b  in  BITMASK_WIDTH  weight-nonzero mask, sampled on load.
- weight_base  in  ADDR_WIDTH  row base address, sampled on load.
- and_result  out  BITMASK_WIDTH  registered a & b of the current load, held until the next load.
- bitmask_a_out  out  BITMASK_WIDTH  registered bitmask_a, held until the next load.
- weight_rd_en  out  1  SRAM read strobe.
- weight_addr  out  ADDR_WIDTH  SRAM read address.
- weight_rdata  in  WEIGHT_WIDTH  SRAM data, valid exactly 1 cycle after weight_rd_en.
- match_valid  out  1  output holds a match.
- match_ready  in  1  downstream accepts (tied to !fifo_full).
- matched_position  out  clog2(BITMASK_WIDTH)  matched bit index.
- matched_weight  out  WEIGHT_WIDTH  weight for that index.
- scan_done  out  1  one-cycle pulse once the last match of a load is accepted, or the load had no matches.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; load_ready=1.
  - match_valid=0, weight_rd_en=0, scan_done=0.
  - and_result, bitmask_a_out, matched_position, matched_weight, weight_addr all 0.
  - Skid buffer and in-flight flag cleared.
  - Reset mid-scan abandons the scan; any returning rdata is ignored.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE:
  - load_ready=1.
  - On accept: register the masks, remaining = a & b, and base.
  - Go to SCAN if remaining != 0. Otherwise pulse scan_done the next cycle and stay in IDLE.
- SCAN, per cycle issue rule:
  - Issue when remaining != 0 and the skid buffer is empty.
  - On issue: pos = lowest set bit of remaining; weight_rd_en=1; weight_addr = base + popcount(bitmask_b & ((1<<pos)-1)), modulo 2^ADDR_WIDTH; clear bit pos; record pos in flight.
  - When the last bit is issued, go to DRAIN.
- Return path (cycle after issue):
  - rdata and pos load the output register if it is empty or being accepted this cycle.
  - Otherwise they load the 1-entry skid buffer.
  - The skid buffer moves to the output register when the output is freed; the output register is refilled before any newer data.
- Ordering and latency:
  - Positions leave in strictly ascending order.
  - Load-to-first-match_valid latency: 3 cycles (load, issue, output).
- Throughput:
  - Sustained 1 match/cycle while match_ready=1.
  - With match_ready=0, at most 1 further issue occurs (it fills the skid buffer), then issue stops.
  - match_valid, matched_position and matched_weight hold stable while match_valid && !match_ready.
- DRAIN:
  - Leave when nothing is in flight, the skid buffer is empty, and the output is accepted.
  - scan_done pulses in the cycle after that acceptance; FSM returns to IDLE.
- load_valid while busy: ignored (load_ready=0).
- Full mask (all bits set in both): BITMASK_WIDTH matches; addresses base+0 .. base+WIDTH-1.

Optional Feature:
- Macro: SCANNER_STATS_EN.
- Defined:
  - Adds outputs stat_matches[15:0] and stat_stall_cycles[15:0].
  - stat_matches increments per accepted match.
  - stat_stall_cycles increments per cycle with match_valid && !match_ready.
  - Both saturate at 0xFFFF and clear only on reset.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Basic pairing. Setup: mem[base+0]=0x2C, mem[base+2]=0x5A, base=0x040; a=0x002C, b=0x0034; match_ready=1. Expected: and_result=0x0024; matches (2,0x2C) then (5,0x5A) on consecutive cycles; addresses 0x040 and 0x042; scan_done one cycle after the second accept.
- Empty AND. a=0x00F0, b=0x000F. Expected: no weight_rd_en, no match_valid; scan_done pulses 1 cycle after load; load_ready returns to 1.
- Backpressure. a=b=0x000F; match_ready=0 for 4 cycles starting when match_valid first rises. Expected: output holds (0,mem[base]); exactly one extra read issued; after release, positions 0,1,2,3 arrive in order, none lost or duplicated.
- Full mask with wrap. a=b=0xFFFF, base=0x3FE. Expected: 16 matches, positions 0..15; addresses wrap 0x3FE, 0x3FF, 0x000, ... 0x00D.
- Reset mid-scan. rst_n low during SCAN of a=b=0x0FF0. Expected: all outputs 0 immediately (async); after release, a fresh load a=0x0001, b=0x0001 yields a single match (0,mem[base]).
- Stats (SCANNER_STATS_EN defined). Rerun the backpressure test. Expected: stat_matches=4, stat_stall_cycles=4.
